cbfp_frame_sched: RTL
=====================

Name: cbfp_frame_sched

Overview:
- Control-only scheduler in front of the 16-lane CBFP normalisation stage.
- Admits 16-lane beats from upstream and asserts the CBFP valid. Tracks beat and frame position.
- Captures the per-block exponent indices produced for each admitted beat into an exponent FIFO.
- The FIFO is drained by the downstream de-normalisation stage over a valid/ready handshake.

Parameters:
- NCHAN, 16, lanes per beat
- BLOCK_SIZE, 8, lanes sharing one exponent
- NBLOCKS, NCHAN/BLOCK_SIZE (2), exponents per beat
- IDX_W, 5, exponent index width ($clog2 of 25-bit datapath)
- BEATS_PER_FRAME, 32, beats per FFT frame (512 points / 16)
- FIFO_DEPTH, 64, exponent FIFO entries (power of two, >= BEATS_PER_FRAME)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of counters/FIFO, lower priority than rst
- in_valid  in  1  upstream beat available
- in_ready  out  1  beat may be accepted
- idx_in  in  NBLOCKS*IDX_W  per-block exponents of the current beat, block 0 in LSBs
- cbfp_valid  out  1  drives CBFP valid_in; = in_valid & in_ready
- beat_cnt  out  $clog2(BEATS_PER_FRAME)  index of the beat being accepted
- frame_start  out  1  accepted beat is beat 0
- frame_last  out  1  accepted beat is beat BEATS_PER_FRAME-1
- frame_done  out  1  one-cycle pulse, cycle after last beat accepted
- frame_cnt  out  16  completed frames, wraps at 2^16
- exp_valid  out  1  FIFO non-empty
- exp_ready  in  1  downstream pops an entry
- exp_data  out  NBLOCKS*IDX_W  head entry exponents
- exp_last  out  1  head entry is last beat of a frame
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values (rst=1): state IDLE; beat_cnt, frame_cnt, fifo_level, pointers = 0. frame_done = 0, exp_valid = 0, in_ready = 0 during the rst cycle.
- Accept: accept = in_valid & in_ready, where in_ready = !rst & !flush & (fifo_level < FIFO_DEPTH).
- Full: a pop in the same cycle does not free space for a push (conservative full).
- Sampling: on accept, idx_in and (beat_cnt == BEATS_PER_FRAME-1) are written as one FIFO entry. Zero-cycle latency; idx_in is sampled in the same cycle as cbfp_valid.
- FSM states IDLE and RUN:
  - IDLE: beat_cnt = 0. An accept asserts frame_start and moves to RUN, with beat_cnt -> 1.
  - RUN: each accept increments beat_cnt. An accept at BEATS_PER_FRAME-1 asserts frame_last, resets beat_cnt to 0, returns to IDLE, increments frame_cnt and pulses frame_done next cycle.
  - BEATS_PER_FRAME = 1: frame_start and frame_last assert together.
  - Gaps (in_valid low) hold state; there is no timeout.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Show-ahead: exp_data and exp_last reflect mem[rd_ptr] combinationally; exp_valid = (fifo_level != 0).
  - Pop = exp_valid & exp_ready. exp_ready with an empty FIFO is ignored.
  - Simultaneous push and pop leaves fifo_level unchanged, pointers both advance.
- flush:
  - Same-cycle in_valid is not accepted.
  - Next cycle: IDLE, beat_cnt = 0, FIFO empty. frame_cnt is preserved; no frame_done pulse.
- Reset mid-frame: partial frame discarded, frame_cnt not incremented.
- cbfp_valid, beat_cnt, frame_start and frame_last are combinational from the current state and in_valid.

Optional Feature:
- Macro CBFP_FRAME_MIN_EN.
- Defined:
  - Adds output frame_min_idx [IDX_W-1:0], which holds the minimum of all exponents of all blocks in the last completed frame.
  - A running minimum is reset to all-ones at frame_start.
  - frame_min_idx updates in the frame_done cycle and holds until the next frame_done.
  - Reset value of frame_min_idx is 0.
- Undefined: the port and logic are absent.

Decomposition:
- Package cbfp_pkg:
  - IDX_W and NBLOCKS constants
  - typedef idx_t (logic [IDX_W-1:0])
  - typedef exp_entry_t, a packed struct {logic last; idx_t [NBLOCKS-1:0] idx;}
  - sched_state_e enum {IDLE, RUN}
- Sub-module cbfp_exp_fifo: synchronous FIFO of exp_entry_t with push, pop, level, show-ahead head.

Test Plan:
- Reset, then 32 back-to-back beats, idx_in = {b,b} with b = beat mod 25, exp_ready = 1 -> frame_start on beat 0, frame_last on beat 31, frame_done one cycle later, frame_cnt = 1, exp_data matches in order, exp_last only on entry 31.
- exp_ready = 0, 70 beats offered -> in_ready drops after 64 accepts, fifo_level = 64. Raise exp_ready -> one pop per cycle, no push in the full+pop cycle, in_ready returns the next cycle.
- Random in_valid/exp_ready gaps over 4 frames -> no lost or duplicated entries, beat_cnt is continuous across gaps, frame_cnt = 4.
- flush asserted at beat 10 with in_valid = 1 -> that beat is not accepted, next cycle fifo_level = 0 and beat_cnt = 0. The next accept asserts frame_start, frame_cnt is unchanged.
- rst pulse mid-frame at beat 20 -> all outputs return to reset values, next frame starts at beat 0.
- CBFP_FRAME_MIN_EN: frame with all idx = 12 except one block idx = 3 at beat 17 -> frame_min_idx = 3 at frame_done. The next frame with all idx = 9 -> 9.

Source files
------------

// File: rtl/cbfp_frame_sched_pkg.sv
// Shared types for the CBFP frame scheduler: exponent index, FIFO entry and FSM state.
package cbfp_pkg;

  localparam int unsigned NCHAN      = 16;
  localparam int unsigned BLOCK_SIZE = 8;
  localparam int unsigned NBLOCKS    = NCHAN / BLOCK_SIZE;
  localparam int unsigned IDX_W      = 5;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic                   last;
    idx_t [NBLOCKS-1:0]     idx;
  } exp_entry_t;

  typedef enum logic {IDLE, RUN} sched_state_e;

  // Smallest exponent among the blocks of one beat.
  function automatic idx_t min_idx(input idx_t [NBLOCKS-1:0] v);
    idx_t m;
    m = '1;
    for (int unsigned i = 0; i < NBLOCKS; i++) begin
      if (v[i] < m) m = v[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/cbfp_frame_sched_if.sv
// Beat admission and exponent drain handshakes of the CBFP frame scheduler.
interface cbfp_frame_sched_if;
  import cbfp_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [NBLOCKS*IDX_W-1:0] idx_in;
  logic                     exp_valid;
  logic                     exp_ready;
  logic [NBLOCKS*IDX_W-1:0] exp_data;
  logic                     exp_last;

  modport slave (
    input  in_valid, idx_in, exp_ready,
    output in_ready, exp_valid, exp_data, exp_last
  );

  modport master (
    output in_valid, idx_in, exp_ready,
    input  in_ready, exp_valid, exp_data, exp_last
  );

endinterface

// File: rtl/cbfp_frame_sched_exp_fifo.sv
// Show-ahead circular FIFO of exponent entries; clr empties it like reset.
module cbfp_exp_fifo
  import cbfp_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  exp_entry_t    din,
  input  logic          pop,
  output exp_entry_t    head,
  output logic [LW-1:0] level
);

  exp_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the current level only, so a same-cycle pop never makes room.
  assign do_push = push && (level < LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/cbfp_frame_sched.sv
// Beat/frame scheduler in front of the CBFP stage with an exponent FIFO.
// Optional CBFP_FRAME_MIN_EN adds frame_min_idx, the minimum exponent of the last frame.
module cbfp_frame_sched
  import cbfp_pkg::*;
#(
  parameter  int unsigned BEATS_PER_FRAME = 32,
  parameter  int unsigned FIFO_DEPTH      = 64,
  localparam int unsigned CNT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1,
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  cbfp_frame_sched_if.slave  bus,
  output logic               cbfp_valid,
  output logic [CNT_W-1:0]   beat_cnt,
  output logic               frame_start,
  output logic               frame_last,
  output logic               frame_done,
  output logic [15:0]        frame_cnt,
  output logic [LVL_W-1:0]   fifo_level
`ifdef CBFP_FRAME_MIN_EN
  , output idx_t             frame_min_idx
`endif
);

  sched_state_e state;
  logic         accept;
  logic         last_beat;
  logic         done_q;
  exp_entry_t   push_entry;
  exp_entry_t   head;

  assign bus.in_ready = !rst && !flush && (fifo_level < LVL_W'(FIFO_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign cbfp_valid   = accept;
  assign last_beat    = (beat_cnt == CNT_W'(BEATS_PER_FRAME - 1));
  assign frame_start  = accept && (state == IDLE);
  assign frame_last   = accept && last_beat;
  assign frame_done   = done_q && !rst;

  always_comb begin
    push_entry      = '0;
    push_entry.last = last_beat;
    push_entry.idx  = bus.idx_in;
  end

  // beat_cnt is held at 0 whenever the FSM is in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      done_q    <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      beat_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          state     <= IDLE;
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
          done_q    <= 1'b1;
        end else begin
          state    <= RUN;
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

  cbfp_exp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (accept),
    .din   (push_entry),
    .pop   (bus.exp_valid && bus.exp_ready),
    .head  (head),
    .level (fifo_level)
  );

  assign bus.exp_valid = (fifo_level != '0) && !rst;
  assign bus.exp_data  = head.idx;
  assign bus.exp_last  = head.last;

`ifdef CBFP_FRAME_MIN_EN
  idx_t run_min;
  idx_t beat_min;
  idx_t acc_min;

  // Starting from all-ones at frame_start reduces to taking this beat's minimum.
  always_comb begin
    beat_min = min_idx(bus.idx_in);
    acc_min  = (state == IDLE) ? beat_min : ((beat_min < run_min) ? beat_min : run_min);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min       <= '1;
      frame_min_idx <= '0;
    end else if (accept) begin
      run_min <= acc_min;
      if (last_beat) frame_min_idx <= acc_min;
    end
  end
`endif

endmodule
